// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: column scan, per-scan debounce FSM and a 4-digit
// shift register of accepted keys.
module hex_keypad_entry #(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;

  state_t           state, state_next;
  logic [DB_W-1:0]  deb, deb_next;
  logic [3:0]       cand, cand_next;
  logic             accept;

  logic [3:0]       row_m, row_s;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             sample, scan_end;

  logic [2:0]       col_hits;
  logic [3:0]       col_code;
  logic [1:0]       acc_hits;
  logic [3:0]       acc_code;
  logic [2:0]       scan_hits;
  logic [3:0]       scan_code;
  logic             scan_none, scan_single;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign col      = ~(4'b0001 << col_idx);
  assign sample   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_end = sample && (col_idx == 2'd3);

  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(2'(r), col_idx);
      end
    end
  end

  // Running hit count saturates at 2: only none / single / multi matter.
  assign scan_hits   = {1'b0, acc_hits} + col_hits;
  assign scan_code   = (acc_hits != 2'd0) ? acc_code : col_code;
  assign scan_none   = (scan_hits == 3'd0);
  assign scan_single = (scan_hits == 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_m    <= '1;
      row_s    <= '1;
      div_cnt  <= '0;
      col_idx  <= '0;
      acc_hits <= '0;
      acc_code <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      if (sample) begin
        div_cnt  <= '0;
        col_idx  <= col_idx + 2'd1;
        acc_code <= scan_code;
        if (col_idx == 2'd3)
          acc_hits <= '0;
        else
          acc_hits <= (scan_hits >= 3'd2) ? 2'd2 : scan_hits[1:0];
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    deb_next   = deb;
    cand_next  = cand;
    accept     = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            cand_next = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept     = 1'b1;
              state_next = HELD;
              deb_next   = '0;
            end else begin
              state_next = CAND;
              deb_next   = DB_W'(1);
            end
          end
        end
        CAND: begin
          if (scan_single && scan_code == cand) begin
            if (32'(deb) + 32'd1 == DEBOUNCE_SCANS) begin
              accept     = 1'b1;
              state_next = HELD;
              deb_next   = '0;
            end else begin
              deb_next = deb + DB_W'(1);
            end
          end else if (scan_single) begin
            cand_next = scan_code;
            deb_next  = DB_W'(1);
          end else begin
            state_next = IDLE;
            deb_next   = '0;
          end
        end
        HELD: begin
          if (scan_none) begin
            if (32'(deb) + 32'd1 == DEBOUNCE_SCANS) begin
              state_next = IDLE;
              deb_next   = '0;
            end else begin
              deb_next = deb + DB_W'(1);
            end
          end else begin
            deb_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          deb_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      deb       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      value     <= '0;
    end else begin
      state     <= state_next;
      deb       <= deb_next;
      cand      <= cand_next;
      key_valid <= accept;
      if (accept)
        key_code <= scan_code;
      if (clear)
        value <= '0;
      else if (accept)
        value <= {value[11:0], scan_code};
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Randomized scan-level bench for hex_keypad_entry with a keypad model and a
// debounce reference evaluated once per full scan.
module tb_hex_keypad_entry;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 3;
  localparam int          SCAN_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;

  always #5 clk = ~clk;

  hex_keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clear(clear),
    .value(value), .key_code(key_code), .key_valid(key_valid)
  );

  // Physical key layout, index = row*4 + col.
  localparam logic [3:0] LAYOUT [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'h0, 4'hF, 4'hE, 4'hD};

  logic [15:0] pressed;
  bit          force_low;

  always_comb begin
    row = '1;
    if (force_low) row = '0;
    else
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (!col[c] && pressed[LAYOUT[r*4+c]]) row[r] = 1'b0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: debounce expressed as run lengths of identical scan results.
  bit          held;
  int          run_len, none_run;
  logic [3:0]  run_key;
  logic        want_kv;
  logic [3:0]  want_code;
  logic [15:0] want_value;

  task automatic model_reset();
    held = 0; run_len = 0; none_run = 0; run_key = '0;
    want_kv = 1'b0; want_code = '0; want_value = '0;
  endtask

  task automatic model_scan(input logic [15:0] keys, output bit acc, output logic [3:0] k);
    int n;
    n = $countones(keys);
    acc = 0;
    k = '0;
    for (int d = 0; d < 16; d++) if (keys[d]) k = 4'(d);
    if (!held) begin
      if (n == 1) begin
        if (run_len > 0 && run_key == k) run_len++;
        else begin run_key = k; run_len = 1; end
        if (run_len == int'(DB)) begin acc = 1; held = 1; none_run = 0; run_len = 0; end
      end else run_len = 0;
    end else begin
      if (n == 0) begin
        none_run++;
        if (none_run == int'(DB)) held = 0;
      end else none_run = 0;
    end
  endtask

  function automatic logic [15:0] kbit(input int k);
    return 16'(1) << k;
  endfunction

  // Runs ncyc cycles of one scan with the given keys held; clr_at = cycle index
  // within the scan where clear is driven (-1 for none).
  task automatic do_scan(input logic [15:0] keys, input int ncyc, input int clr_at);
    bit         acc;
    logic [3:0] k;
    logic [3:0] ecol;
    pressed = keys;
    for (int i = 0; i < ncyc; i++) begin
      ecol = ~(4'b0001 << (i / int'(SCAN_DIV)));
      check("col", {12'h0, col}, {12'h0, ecol});
      check("key_valid", {15'h0, key_valid}, {15'h0, want_kv});
      check("key_code", {12'h0, key_code}, {12'h0, want_code});
      check("value", value, want_value);
      want_kv = 1'b0;
      if (i == SCAN_CYC - 1) begin
        model_scan(keys, acc, k);
        if (acc) begin
          want_kv = 1'b1;
          want_code = k;
          want_value = {want_value[11:0], k};
        end
      end
      if (i == clr_at) begin
        clear = 1'b1;
        want_value = '0;
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
    end
  endtask

  task automatic scans(input logic [15:0] keys, input int n);
    repeat (n) do_scan(keys, SCAN_CYC, -1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_col", {12'h0, col}, 16'h000E);
      check("rst_key_valid", {15'h0, key_valid}, 16'h0000);
      check("rst_value", value, 16'h0000);
      check("rst_key_code", {12'h0, key_code}, 16'h0000);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic tap(input int k);
    scans(kbit(k), int'(DB) + int'($urandom_range(0, 2)));
    scans('0, int'(DB) + int'($urandom_range(0, 1)));
  endtask

  logic [15:0] cur;
  int          sel, clr;

  initial begin
    clear = 1'b0;
    pressed = '0;
    force_low = 1'b1;
    model_reset();
    do_reset(5);
    force_low = 1'b0;

    scans('0, 1);

    // single press of '5' held 5 scans
    scans(kbit(5), 5);
    scans('0, 3);

    // bounce on '9'
    scans(kbit(9), 2);
    scans('0, 1);
    scans(kbit(9), 3);
    scans('0, 3);

    // entry sequence after a quiet-cycle clear
    do_scan('0, SCAN_CYC, 5);
    tap(1); tap(10); tap(3); tap(15); tap(7);

    // 'D' held, then '2' added (multi), then ragged release
    scans(kbit(13), 4);
    scans(kbit(13) | kbit(2), 3);
    scans(kbit(13), 1);
    scans('0, 2);
    scans(kbit(13) | kbit(2), 1);
    scans('0, 3);
    scans('0, 1);

    // clear colliding with the accept of 'E'
    do_scan('0, SCAN_CYC, 9);
    tap(1); tap(2); tap(3); tap(4);
    scans(kbit(14), int'(DB) - 1);
    do_scan(kbit(14), SCAN_CYC, SCAN_CYC - 1);
    scans('0, 3);

    // reset in the middle of debounce and mid-scan with the key still down
    scans(kbit(8), 2);
    do_scan(kbit(8), 7, -1);
    do_reset(3);
    scans(kbit(8), 4);
    scans('0, 3);

    // random key activity
    cur = '0;
    repeat (60) begin
      sel = int'($urandom_range(0, 9));
      if (sel >= 4 && sel < 6) cur = '0;
      else if (sel >= 6 && sel < 9) cur = kbit(int'($urandom_range(0, 15)));
      else if (sel == 9) cur = kbit(int'($urandom_range(0, 15))) | kbit(int'($urandom_range(0, 15)));
      clr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, SCAN_CYC - 1)) : -1;
      do_scan(cur, SCAN_CYC, clr);
    end
    scans('0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
